// File: rtl/control_word_decode_stage.sv
// control_word_decode_stage: registered, skid-buffered split of a microcode control word into datapath fields
module control_word_decode_stage #(
  parameter int OPCODE_W = 7,
  parameter int FS_W = 5,
  parameter int RA_W = 5,
  parameter int CNT_W = 16,
  parameter int WORD_W = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [WORD_W-1:0]   in_word,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [OPCODE_W-1:0] opcode,
  output logic                rw,
  output logic [1:0]          md,
  output logic [1:0]          bs,
  output logic                ps,
  output logic                mw,
  output logic [FS_W-1:0]     fs,
  output logic                ma,
  output logic                mb,
  output logic [RA_W-1:0]     aa,
  output logic [RA_W-1:0]     ba,
  output logic                cs,
  output logic                md_illegal,
  input  logic                cnt_clr,
  output logic [CNT_W-1:0]    dec_count
);
  localparam int B = WORD_W - OPCODE_W;
  if (WORD_W != OPCODE_W + FS_W + 2*RA_W + 10) begin : g_bad_width
    $error("WORD_W must equal OPCODE_W+FS_W+2*RA_W+10");
  end
  logic [WORD_W-1:0] or_w, sr_w;
  logic or_v, sr_v, or_ill, sr_ill;
  logic acc, drain, in_ill;
  assign in_ready = ~sr_v;
  assign acc = in_valid & ~sr_v;
  assign drain = or_v & out_ready;
  assign in_ill = in_word[B-2 -: 2] == 2'b11;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      or_w <= '0;
      sr_w <= '0;
      or_v <= 1'b0;
      sr_v <= 1'b0;
      or_ill <= 1'b0;
      sr_ill <= 1'b0;
    end else if (flush) begin
      or_v <= 1'b0;
      sr_v <= 1'b0;
    end else if (drain | ~or_v) begin
      or_v <= sr_v | acc;
      if (sr_v) begin
        or_w <= sr_w;
        or_ill <= sr_ill;
        sr_v <= 1'b0;
      end else if (acc) begin
        or_w <= in_word;
        or_ill <= in_ill;
      end
    end else if (acc) begin
      sr_w <= in_word;
      sr_ill <= in_ill;
      sr_v <= 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n || cnt_clr) dec_count <= '0;
    else if (drain && dec_count != '1) dec_count <= dec_count + 1'b1;
  end
  assign out_valid = or_v;
  assign md_illegal = or_ill;
  assign opcode = or_w[WORD_W-1 -: OPCODE_W];
  assign rw = or_w[B-1];
  assign md = or_w[B-2 -: 2];
  assign bs = or_w[B-4 -: 2];
  assign ps = or_w[B-6];
  assign mw = or_w[B-7];
  assign fs = or_w[B-8 -: FS_W];
  assign ma = or_w[2*RA_W+2];
  assign mb = or_w[2*RA_W+1];
  assign aa = or_w[2*RA_W -: RA_W];
  assign ba = or_w[RA_W -: RA_W];
  assign cs = or_w[0];
endmodule

// File: tb/tb_control_word_decode_stage.sv
// tb_control_word_decode_stage: directed vector table plus handshake, flush, reset and counter sequences
module tb_control_word_decode_stage;
  logic clk = 0;
  always #5 clk = ~clk;
  logic rst_n, flush, in_valid, in_ready, out_valid, out_ready, cnt_clr;
  logic [31:0] in_word;
  logic [6:0] opcode;
  logic rw, ps, mw, ma, mb, cs, md_illegal;
  logic [1:0] md, bs;
  logic [4:0] fs, aa, ba;
  logic [15:0] dec_count;
  logic [31:0] gw;
  assign gw = {opcode, rw, md, bs, ps, mw, fs, ma, mb, aa, ba, cs};
  control_word_decode_stage dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_word(in_word), .out_valid(out_valid), .out_ready(out_ready), .opcode(opcode),
    .rw(rw), .md(md), .bs(bs), .ps(ps), .mw(mw), .fs(fs), .ma(ma), .mb(mb), .aa(aa),
    .ba(ba), .cs(cs), .md_illegal(md_illegal), .cnt_clr(cnt_clr), .dec_count(dec_count));
  logic v4, r4, clr4, ir4, ov4, rw4, ps4, mw4, ma4, mb4, cs4, il4;
  logic [31:0] w4;
  logic [6:0] op4;
  logic [1:0] md4, bs4;
  logic [4:0] fs4, aa4, ba4;
  logic [3:0] cnt4;
  control_word_decode_stage #(.CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .flush(1'b0), .in_valid(v4), .in_ready(ir4),
    .in_word(w4), .out_valid(ov4), .out_ready(r4), .opcode(op4),
    .rw(rw4), .md(md4), .bs(bs4), .ps(ps4), .mw(mw4), .fs(fs4), .ma(ma4), .mb(mb4), .aa(aa4),
    .ba(ba4), .cs(cs4), .md_illegal(il4), .cnt_clr(clr4), .dec_count(cnt4));
  logic v40, ir40, ov40, rw40, ps40, mw40, ma40, mb40, cs40, il40;
  logic [39:0] w40;
  logic [11:0] op40;
  logic [1:0] md40, bs40;
  logic [5:0] fs40, aa40, ba40;
  logic [15:0] cnt40;
  control_word_decode_stage #(.OPCODE_W(12), .FS_W(6), .RA_W(6), .WORD_W(40)) dut40 (
    .clk(clk), .rst_n(rst_n), .flush(1'b0), .in_valid(v40), .in_ready(ir40),
    .in_word(w40), .out_valid(ov40), .out_ready(1'b1), .opcode(op40),
    .rw(rw40), .md(md40), .bs(bs40), .ps(ps40), .mw(mw40), .fs(fs40), .ma(ma40), .mb(mb40), .aa(aa40),
    .ba(ba40), .cs(cs40), .md_illegal(il40), .cnt_clr(1'b0), .dec_count(cnt40));
  typedef struct {
    logic [31:0] w;
    logic [6:0] op;
    logic rw;
    logic [1:0] md, bs;
    logic ps, mw;
    logic [4:0] fs;
    logic ma, mb;
    logic [4:0] aa, ba;
    logic cs, ill;
  } vec_t;
  vec_t vt[4];
  logic [31:0] wq[4];
  int total = 0, bad = 0, si, ri, n;
  logic [15:0] cnt_before;
  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic cycle();
    logic a, h;
    a = in_valid & in_ready;
    h = out_valid & out_ready;
    if (h) begin
      if (ri < 4) chk("order", gw, wq[ri]);
      else chk("extra_word", ri, 3);
      ri++;
    end
    tick();
    if (a) si++;
    in_valid = si < 4;
    in_word = wq[si < 4 ? si : 3];
  endtask
  initial begin
    vt[0] = '{32'hFFFF_FFFF, 7'h7F, 1, 2'b11, 2'b11, 1, 1, 5'h1F, 1, 1, 5'h1F, 5'h1F, 1, 1};
    vt[1] = '{32'h0000_0001, 7'h00, 0, 2'b00, 2'b00, 0, 0, 5'h00, 0, 0, 5'h00, 5'h00, 1, 0};
    vt[2] = '{{7'h55, 1'b0, 2'b10, 2'b01, 1'b1, 1'b0, 5'h0A, 1'b1, 1'b0, 5'h13, 5'h0C, 1'b0},
              7'h55, 0, 2'b10, 2'b01, 1, 0, 5'h0A, 1, 0, 5'h13, 5'h0C, 0, 0};
    vt[3] = '{{7'h01, 1'b1, 2'b11, 2'b00, 1'b0, 1'b1, 5'h11, 1'b0, 1'b1, 5'h01, 5'h1E, 1'b1},
              7'h01, 1, 2'b11, 2'b00, 0, 1, 5'h11, 0, 1, 5'h01, 5'h1E, 1, 1};
    wq[0] = 32'h1234_5670; wq[1] = 32'h89AB_CDE1; wq[2] = 32'h0F0F_0F0E; wq[3] = 32'hC001_D00D;
    rst_n = 0; flush = 0; in_valid = 0; in_word = 0; out_ready = 0; cnt_clr = 0;
    v4 = 0; w4 = 32'h0000_0003; r4 = 1; clr4 = 0; v40 = 0; w40 = 0;
    tick(); tick();
    rst_n = 1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_fields", {gw, md_illegal}, 0);
    chk("rst_count", dec_count, 0);
    out_ready = 1;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1;
      in_word = vt[i].w;
      tick();
      chk($sformatf("vec%0d_valid", i), out_valid, 1);
      chk($sformatf("vec%0d_fields", i),
          {vt[i].op, vt[i].rw, vt[i].md, vt[i].bs, vt[i].ps, vt[i].mw, vt[i].fs,
           vt[i].ma, vt[i].mb, vt[i].aa, vt[i].ba, vt[i].cs, vt[i].ill},
          {opcode, rw, md, bs, ps, mw, fs, ma, mb, aa, ba, cs, md_illegal});
    end
    in_valid = 0;
    tick();
    chk("vec_count", dec_count, 4);
    chk("vec_drained", out_valid, 0);
    out_ready = 0; si = 0; ri = 0;
    in_valid = 1; in_word = wq[0];
    cycle(); cycle();
    chk("bp_accepted2", si, 2);
    chk("bp_in_ready", in_ready, 0);
    chk("bp_shows_a", gw, wq[0]);
    cycle(); cycle();
    chk("bp_still2", si, 2);
    chk("bp_hold_a", {out_valid, gw}, {1'b1, wq[0]});
    out_ready = 1; n = 0;
    while (ri < 4 && n < 20) begin
      cycle();
      n++;
    end
    chk("bp_all_out", ri, 4);
    chk("bp_no_gaps", n, 4);
    cycle(); cycle();
    chk("bp_no_dup", {out_valid, 32'(ri)}, {1'b0, 32'd4});
    out_ready = 0;
    in_valid = 1; in_word = wq[0]; tick();
    in_word = wq[1]; tick();
    chk("fl_sr_full", in_ready, 0);
    cnt_before = dec_count;
    in_word = wq[2]; flush = 1; tick();
    flush = 0; in_valid = 0;
    chk("fl_out_valid", out_valid, 0);
    chk("fl_in_ready", in_ready, 1);
    chk("fl_count", dec_count, cnt_before);
    in_valid = 1; in_word = wq[0]; tick();
    in_word = wq[2]; flush = 1; tick();
    flush = 0; in_valid = 0; out_ready = 1;
    chk("fl_drop_c", out_valid, 0);
    tick(); tick();
    chk("fl_nothing_after", out_valid, 0);
    out_ready = 0;
    in_valid = 1; in_word = vt[0].w; tick();
    in_word = vt[3].w; tick();
    chk("rs_full", {out_valid, in_ready}, 2'b10);
    rst_n = 0; in_valid = 0; tick();
    rst_n = 1;
    chk("rs_flags", {out_valid, in_ready, md_illegal}, 3'b010);
    chk("rs_fields", gw, 0);
    chk("rs_count", dec_count, 0);
    out_ready = 1; tick(); tick();
    chk("rs_no_stale", out_valid, 0);
    v40 = 1;
    w40 = {12'hC3A, 7'b0, 6'h00, 2'b00, 6'h2A, 6'h15, 1'b1};
    tick();
    v40 = 0;
    chk("w40_fields", {ov40, op40, aa40, ba40, cs40}, {1'b1, 12'hC3A, 6'h2A, 6'h15, 1'b1});
    v4 = 1;
    repeat (6) tick();
    chk("sat_counting", cnt4, 5);
    repeat (20) tick();
    chk("sat_stop", cnt4, 15);
    clr4 = 1; tick();
    clr4 = 0;
    chk("sat_clr_wins", cnt4, 0);
    tick();
    chk("sat_after_clr", cnt4, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
